// File: rtl/neuron_pkg.sv
// Shared constants, state encoding and payload types for the neuron scheduler slice.
package neuron_pkg;

  localparam int unsigned INT_W = 3;
  localparam int unsigned FRC_W = 12;
  localparam int unsigned W     = 1 + INT_W + FRC_W;

  localparam int unsigned           DEF_N_NEURONS = 8;
  localparam logic [W-1:0]          DEF_V_INIT    = 16'hECE1;
  localparam logic [W-1:0]          DEF_W_INIT    = 16'hF600;
  localparam logic signed [W-1:0]   DEF_V_THRESH  = 16'sh1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [W-1:0] v;
    logic [W-1:0] w;
  } nstate_t;

endpackage

// File: rtl/neuron_scheduler_if.sv
// Controller, current source, datapath and spike sink signals of the neuron scheduler.
interface neuron_scheduler_if
  import neuron_pkg::*;
#(
  parameter int unsigned N_NEURONS = DEF_N_NEURONS
);
  localparam int unsigned IDX_W = $clog2(N_NEURONS);

  logic             start;
  logic             clear;
  logic             busy;
  logic             done;
  logic [15:0]      step_cnt;
  logic [IDX_W-1:0] i_idx;
  logic [W-1:0]     i_data;
  logic [W-1:0]     dp_v;
  logic [W-1:0]     dp_w;
  logic [W-1:0]     dp_i;
  logic [W-1:0]     dp_v_next;
  logic [W-1:0]     dp_w_next;
  logic             spike_valid;
  logic [IDX_W-1:0] spike_idx;
  logic             spike_ready;
  logic [IDX_W-1:0] rd_idx;
  logic [W-1:0]     rd_v;
  logic [W-1:0]     rd_w;

  // Scheduler side
  modport slave (
    input  start, clear, i_data, dp_v_next, dp_w_next, spike_ready, rd_idx,
    output busy, done, step_cnt, i_idx, dp_v, dp_w, dp_i, spike_valid, spike_idx, rd_v, rd_w
  );

  // Network controller / datapath / sink side
  modport master (
    output start, clear, i_data, dp_v_next, dp_w_next, spike_ready, rd_idx,
    input  busy, done, step_cnt, i_idx, dp_v, dp_w, dp_i, spike_valid, spike_idx, rd_v, rd_w
  );

endinterface

// File: rtl/neuron_state_rf.sv
// Per-neuron v/w register file: one write port, sweep and debug read ports, bulk init.
module neuron_state_rf
  import neuron_pkg::*;
#(
  parameter int unsigned  N_NEURONS = DEF_N_NEURONS,
  parameter logic [W-1:0] V_INIT    = DEF_V_INIT,
  parameter logic [W-1:0] W_INIT    = DEF_W_INIT,
  localparam int unsigned IDX_W     = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  nstate_t          i_wdata,
  input  logic [IDX_W-1:0] i_sw_idx,
  output nstate_t          o_sw_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output nstate_t          o_rd_data
);

  nstate_t r_mem [N_NEURONS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        r_mem[i] <= '{v: V_INIT, w: W_INIT};
      end
    end else if (i_clear) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        r_mem[i] <= '{v: V_INIT, w: W_INIT};
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_sw_data = r_mem[i_sw_idx];
  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/neuron_scheduler.sv
// Sweeps all neurons through the shared v/w update datapath once per timestep and emits spikes.
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int unsigned         N_NEURONS = DEF_N_NEURONS,
  parameter logic signed [W-1:0] V_THRESH  = DEF_V_THRESH,
  parameter logic [W-1:0]        V_INIT    = DEF_V_INIT,
  parameter logic [W-1:0]        W_INIT    = DEF_W_INIT
) (
  input  logic               clk,
  input  logic               rst,
  neuron_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(N_NEURONS);

  sched_state_t     r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_step_cnt;
  logic             r_spike_valid;
  logic [IDX_W-1:0] r_spike_idx;

  nstate_t w_cur;
  nstate_t w_dbg;
  nstate_t w_wdata;
  logic    w_we;
  logic    w_clear;
  logic    w_spike;
  logic    w_last;

  assign w_we    = (r_state == RUN);
  assign w_clear = (r_state == IDLE) && bus.clear;
  assign w_wdata = '{v: bus.dp_v_next, w: bus.dp_w_next};
  assign w_last  = (r_idx == IDX_W'(N_NEURONS - 1));

  // Upward crossing only; a positive-to-negative wrap never satisfies both terms
  assign w_spike = w_we
                && ($signed(bus.dp_v)      <  V_THRESH)
                && ($signed(bus.dp_v_next) >= V_THRESH);

  neuron_state_rf #(
    .N_NEURONS (N_NEURONS),
    .V_INIT    (V_INIT),
    .W_INIT    (W_INIT)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_we      (w_we),
    .i_waddr   (r_idx),
    .i_wdata   (w_wdata),
    .i_sw_idx  (r_idx),
    .o_sw_data (w_cur),
    .i_rd_idx  (bus.rd_idx),
    .o_rd_data (w_dbg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_step_cnt    <= '0;
      r_spike_valid <= 1'b0;
      r_spike_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.clear && bus.start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_spike) begin
            r_spike_valid <= 1'b1;
            r_spike_idx   <= r_idx;
            r_state       <= EMIT;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        EMIT: begin
          if (bus.spike_ready) begin
            r_spike_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= RUN;
            end
          end
        end
        DONE: begin
          r_step_cnt <= r_step_cnt + 16'd1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.step_cnt    = r_step_cnt;
  assign bus.i_idx       = r_idx;
  assign bus.dp_v        = w_cur.v;
  assign bus.dp_w        = w_cur.w;
  assign bus.dp_i        = bus.i_data;
  assign bus.spike_valid = r_spike_valid;
  assign bus.spike_idx   = r_spike_idx;
  assign bus.rd_v        = w_dbg.v;
  assign bus.rd_w        = w_dbg.w;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler with an adder stub datapath (v += i, w unchanged).
module tb_neuron_scheduler;
  import neuron_pkg::*;

  localparam int unsigned N = 8;
  localparam logic [15:0] VI = 16'hECE1;
  localparam logic [15:0] WI = 16'hF600;

  logic clk;
  logic rst;
  logic [15:0] cur [N];
  int total;
  int bad;

  neuron_scheduler_if #(.N_NEURONS(N)) bus ();

  neuron_scheduler #(.N_NEURONS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.i_data    = cur[bus.i_idx];
  assign bus.dp_v_next = bus.dp_v + bus.dp_i;
  assign bus.dp_w_next = bus.dp_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] ev, input logic [15:0] ew);
    for (int i = 0; i < int'(N); i++) begin
      bus.rd_idx = 3'(i);
      #1;
      check_eq($sformatf("%s_v%0d", tag, i), 32'(bus.rd_v), 32'(ev));
      check_eq($sformatf("%s_w%0d", tag, i), 32'(bus.rd_w), 32'(ew));
    end
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
  endtask

  // Starts a sweep and counts edges from the start-accept edge until done is seen.
  task automatic sweep(input int stall, input bit mid_start,
                       output int lat, output int nspk, output int sidx);
    int st;
    st = 0; lat = -1; nspk = 0; sidx = -1;
    bus.spike_ready = 1'(stall == 0);
    bus.rd_idx = 3'd4;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (n == 1) check_eq("busy_run", 32'(bus.busy), 32'd1);
      if (mid_start && n == 3) bus.start = 1'b1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.spike_valid && !bus.spike_ready) begin
        st++;
        check_eq("stall_sidx", 32'(bus.spike_idx), 32'd3);
        check_eq("stall_iidx", 32'(bus.i_idx), 32'd3);
        check_eq("stall_v4", 32'(bus.rd_v), 32'(VI));
        if (st > stall) bus.spike_ready = 1'b1;
      end
      if (bus.spike_valid && bus.spike_ready) begin
        nspk++;
        sidx = int'(bus.spike_idx);
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check_eq("busy_idle", 32'(bus.busy), 32'd0);
    bus.spike_ready = 1'b1;
  endtask

  initial begin
    int lat, nspk, sidx, ndone;
    total = 0; bad = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.clear = 1'b0; bus.spike_ready = 1'b1; bus.rd_idx = '0;
    for (int i = 0; i < int'(N); i++) cur[i] = 16'h0000;

    // 1: reset state
    #12;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_sv", 32'(bus.spike_valid), 32'd0);
    check_eq("rst_step", 32'(bus.step_cnt), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_all("rst", VI, WI);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // 2: uniform current, no spikes
    for (int i = 0; i < int'(N); i++) cur[i] = 16'h0100;
    sweep(0, 1'b0, lat, nspk, sidx);
    check_eq("s2_lat", 32'(lat), 32'd8);
    check_eq("s2_nspk", 32'(nspk), 32'd0);
    check_all("s2", 16'hEDE1, WI);
    check_eq("s2_step", 32'(bus.step_cnt), 32'd1);

    // 3: single spike on neuron 3, sink always ready
    pulse_clear();
    for (int i = 0; i < int'(N); i++) cur[i] = 16'h0000;
    cur[3] = 16'h2400;
    sweep(0, 1'b0, lat, nspk, sidx);
    check_eq("s3_lat", 32'(lat), 32'd9);
    check_eq("s3_nspk", 32'(nspk), 32'd1);
    check_eq("s3_sidx", 32'(sidx), 32'd3);
    bus.rd_idx = 3'd3; #1;
    check_eq("s3_v3", 32'(bus.rd_v), 32'h10E1);
    bus.rd_idx = 3'd4; #1;
    check_eq("s3_v4", 32'(bus.rd_v), 32'(VI));
    check_eq("s3_step", 32'(bus.step_cnt), 32'd2);

    // 4: same spike with the sink stalled three cycles
    pulse_clear();
    sweep(3, 1'b0, lat, nspk, sidx);
    check_eq("s4_lat", 32'(lat), 32'd12);
    check_eq("s4_nspk", 32'(nspk), 32'd1);
    check_eq("s4_sidx", 32'(sidx), 32'd3);
    bus.rd_idx = 3'd3; #1;
    check_eq("s4_v3", 32'(bus.rd_v), 32'h10E1);
    check_eq("s4_step", 32'(bus.step_cnt), 32'd3);

    // 5a: start asserted mid-sweep is ignored
    pulse_clear();
    for (int i = 0; i < int'(N); i++) cur[i] = 16'h0100;
    sweep(0, 1'b1, lat, nspk, sidx);
    check_eq("s5_lat", 32'(lat), 32'd8);
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    check_eq("s5_no_rerun", 32'(ndone), 32'd0);
    check_eq("s5_step", 32'(bus.step_cnt), 32'd4);
    check_all("s5a", 16'hEDE1, WI);

    // 5b: clear and start together -> clear only
    bus.clear = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.start = 1'b0;
    check_eq("s5_cs_busy", 32'(bus.busy), 32'd0);
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    check_eq("s5_cs_nosweep", 32'(ndone), 32'd0);
    check_all("s5b", VI, WI);
    check_eq("s5_cs_step", 32'(bus.step_cnt), 32'd4);

    // 6: reset while parked in EMIT
    for (int i = 0; i < int'(N); i++) cur[i] = 16'h0000;
    cur[3] = 16'h2400;
    bus.spike_ready = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.spike_valid) begin
        ndone = 1;
        break;
      end
    end
    check_eq("s6_reach_emit", 32'(ndone), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("s6_sv", 32'(bus.spike_valid), 32'd0);
    check_eq("s6_busy", 32'(bus.busy), 32'd0);
    check_eq("s6_step", 32'(bus.step_cnt), 32'd0);
    check_all("s6", VI, WI);
    @(negedge clk) rst = 1'b1;
    bus.spike_ready = 1'b1;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check_eq("s6_no_done", 32'(ndone), 32'd0);
    check_eq("s6_busy_after", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
